// File: rtl/half_pair_splitter_if.sv
// Serial-in / paired-out bus of the radix-2 DIF stage front end.
//   data_in        : serial sample {re, im}, 2*float_len bits
//   data_in_valid  : data_in accepted on this clock edge
//   data_out1      : first-half sample x[i]
//   data_out2      : second-half sample x[i+half_len]
//   data_out_valid : single-cycle pair strobe, no backpressure
//   pair_index     : index i of the current pair
//   frame_done     : pulse with the pair i = half_len-1
//   phase          : 0 = FILL, 1 = PAIR (debug)
// slave  = splitter side, master = sample source / pair consumer side.
interface half_pair_splitter_if #(
  parameter int unsigned float_len = 32,
  parameter int unsigned addr_len  = 11
);
  logic [2*float_len-1:0] data_in;
  logic                   data_in_valid;
  logic [2*float_len-1:0] data_out1;
  logic [2*float_len-1:0] data_out2;
  logic                   data_out_valid;
  logic [addr_len-1:0]    pair_index;
  logic                   frame_done;
  logic                   phase;

  modport slave (
    input  data_in, data_in_valid,
    output data_out1, data_out2, data_out_valid, pair_index, frame_done, phase
  );

  modport master (
    output data_in, data_in_valid,
    input  data_out1, data_out2, data_out_valid, pair_index, frame_done, phase
  );
endinterface

// File: rtl/half_pair_splitter.sv
// Front end of a radix-2 DIF stage. Buffers the first half of each frame in
// a synchronous-read RAM, then emits aligned pairs (x[i], x[i+half_len]) as
// the second half streams in, one pair per accepted second-half sample.
// Ports:
//   clk  : stage clock
//   rst  : synchronous active-high reset
//   bus  : half_pair_splitter_if.slave (serial input, paired output, phase)
module half_pair_splitter #(
  parameter int unsigned float_len = 32,
  parameter int unsigned half_len  = 2048,
  parameter int unsigned addr_len  = 11
) (
  input  logic               clk,
  input  logic               rst,
  half_pair_splitter_if.slave bus
);

  localparam int unsigned         W    = 2 * float_len;
  localparam logic [addr_len-1:0] LAST = addr_len'(half_len - 1);

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  state_t              r_state;
  logic [addr_len-1:0] r_cnt;

  // half-frame buffer, no reset so it maps onto block RAM
  logic [W-1:0]        r_mem [half_len];
  logic [W-1:0]        r_rd_data;

  // stage a: registered read address plus the second-half sample
  logic                r_a_valid;
  logic [addr_len-1:0] r_a_addr;
  logic [W-1:0]        r_a_data;

  // stage s1: RAM read data returns alongside the delayed sample
  logic                r_valid1;
  logic [addr_len-1:0] r_s1_cnt;
  logic [W-1:0]        r_s1_data;

  // stage s2: output registers
  logic [W-1:0]        r_out1;
  logic [W-1:0]        r_out2;
  logic                r_out_valid;
  logic [addr_len-1:0] r_pair_index;
  logic                r_frame_done;

  logic                w_wr_en;
  logic                w_rd_issue;
  logic                w_last;

  assign w_last     = (r_cnt == LAST);
  assign w_wr_en    = bus.data_in_valid && (r_state == FILL) && !rst;
  assign w_rd_issue = bus.data_in_valid && (r_state == PAIR);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_cnt] <= bus.data_in;
    end
    if (r_a_valid) begin
      r_rd_data <= r_mem[r_a_addr];
    end
  end

  // Accept at edge k registers the address, the RAM answers at k+1 and the
  // pair lands in the output register at k+2; the sample rides one extra
  // stage so it meets its partner from the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_cnt        <= '0;
      r_a_valid    <= 1'b0;
      r_a_addr     <= '0;
      r_a_data     <= '0;
      r_valid1     <= 1'b0;
      r_s1_cnt     <= '0;
      r_s1_data    <= '0;
      r_out1       <= '0;
      r_out2       <= '0;
      r_out_valid  <= 1'b0;
      r_pair_index <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (bus.data_in_valid) begin
        // half_len is a power of two, so the increment wraps LAST -> 0
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_state <= (r_state == FILL) ? PAIR : FILL;
        end
      end

      r_a_valid <= w_rd_issue;
      if (w_rd_issue) begin
        r_a_addr <= r_cnt;
        r_a_data <= bus.data_in;
      end

      r_valid1 <= r_a_valid;
      if (r_a_valid) begin
        r_s1_cnt  <= r_a_addr;
        r_s1_data <= r_a_data;
      end

      r_out_valid  <= r_valid1;
      r_frame_done <= r_valid1 && (r_s1_cnt == LAST);
      if (r_valid1) begin
        r_out1       <= r_rd_data;
        r_out2       <= r_s1_data;
        r_pair_index <= r_s1_cnt;
      end
    end
  end

  assign bus.data_out1      = r_out1;
  assign bus.data_out2      = r_out2;
  assign bus.data_out_valid = r_out_valid;
  assign bus.pair_index     = r_pair_index;
  assign bus.frame_done     = r_frame_done;
  assign bus.phase          = (r_state == PAIR);

endmodule

// File: tb/tb_half_pair_splitter.sv
// Bench for half_pair_splitter: a small instance (half_len = 4) exercised by
// a vector table and a frame-position reference model, plus a default-size
// instance streaming full 4096-sample frames.
module tb_half_pair_splitter;

  localparam int unsigned F  = 32;
  localparam int unsigned H  = 4;
  localparam int unsigned HB = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_b;

  half_pair_splitter_if #(.float_len(F), .addr_len(2))  s_if ();
  half_pair_splitter_if #(.float_len(F), .addr_len(11)) b_if ();

  half_pair_splitter #(.float_len(F), .half_len(H), .addr_len(2)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  half_pair_splitter #(.float_len(F), .half_len(HB), .addr_len(11)) u_big (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] mk(input int unsigned n);
    logic [31:0] v;
    v  = n;
    mk = {v, ~v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for the small instance ----------------
  // Position within the 2*H sample frame; a second-half sample at edge c is
  // due as a pair right after edge c+2.
  typedef struct {
    int unsigned due;
    logic [63:0] d1;
    logic [63:0] d2;
    int unsigned idx;
    logic        done;
  } pend_t;

  pend_t       q[$];
  logic [63:0] store [H];
  int unsigned pos   = 0;
  int unsigned cyc   = 0;
  logic [63:0] m_d1  = '0;
  logic [63:0] m_d2  = '0;
  int unsigned m_idx = 0;
  int          npairs = 0;

  task automatic step(input logic r, input logic v, input int unsigned n);
    pend_t p;
    logic  ev;
    logic  ed;
    s_if.data_in       = mk(n);
    s_if.data_in_valid = v;
    rst                = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      pos = 0;
      q.delete();
      m_d1 = '0; m_d2 = '0; m_idx = 0;
    end else if (v) begin
      if (pos < H) store[pos] = mk(n);
      else q.push_back('{cyc + 2, store[pos-H], mk(n), pos - H, (pos - H) == H - 1});
      pos = (pos + 1) % (2 * H);
    end
    ev = 1'b0;
    ed = 1'b0;
    if (!r && q.size() > 0 && q[0].due == cyc) begin
      p     = q.pop_front();
      ev    = 1'b1;
      ed    = p.done;
      m_d1  = p.d1;
      m_d2  = p.d2;
      m_idx = p.idx;
    end
    #1;
    if (s_if.data_out_valid === 1'b1) npairs++;
    chk("valid", 64'(s_if.data_out_valid), 64'(ev));
    chk("frame_done", 64'(s_if.frame_done), 64'(ed));
    chk("data_out1", s_if.data_out1, m_d1);
    chk("data_out2", s_if.data_out2, m_d2);
    chk("pair_index", 64'(s_if.pair_index), 64'(m_idx));
    chk("phase", 64'(s_if.phase), 64'(pos >= H));
  endtask

  // ---------------- checker for the default-size instance ----------------
  int unsigned b_i  = 0;
  int unsigned b_fr = 0;
  int          b_pairs = 0;

  task automatic bstep(input logic r, input logic v, input int unsigned n);
    b_if.data_in       = mk(n);
    b_if.data_in_valid = v;
    rst_b              = r;
    @(posedge clk);
    #1;
    if (b_if.data_out_valid === 1'b1) begin
      b_pairs++;
      chk("big_index", 64'(b_if.pair_index), 64'(b_i));
      chk("big_d1", b_if.data_out1, mk(b_fr * 2 * HB + b_i));
      chk("big_d2", b_if.data_out2, mk(b_fr * 2 * HB + b_i + HB));
      chk("big_done", 64'(b_if.frame_done), 64'(b_i == HB - 1));
      b_i++;
      if (b_i == HB) begin
        b_i = 0;
        b_fr++;
      end
    end
  endtask

  // ---------------- vector table: one contiguous frame ----------------
  typedef struct {
    logic        r;
    logic        v;
    int unsigned n;
    logic        ev;
    logic [63:0] e1;
    logic [63:0] e2;
    int unsigned ei;
    logic        ed;
    logic        eph;
  } vec_t;

  vec_t tv [12];

  initial begin
    int base;
    int p0;
    s_if.data_in = '0; s_if.data_in_valid = 1'b0;
    b_if.data_in = '0; b_if.data_in_valid = 1'b0;
    rst = 1'b1; rst_b = 1'b1;

    tv[0]  = '{1'b1, 1'b0, 0, 1'b0, 64'd0, 64'd0, 0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 0, 1'b0, 64'd0, 64'd0, 0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 1, 1'b0, 64'd0, 64'd0, 0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 2, 1'b0, 64'd0, 64'd0, 0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 3, 1'b0, 64'd0, 64'd0, 0, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 1'b1, 4, 1'b0, 64'd0, 64'd0, 0, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 1'b1, 5, 1'b0, 64'd0, 64'd0, 0, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 1'b1, 6, 1'b1, mk(0), mk(4), 0, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 7, 1'b1, mk(1), mk(5), 1, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 0, 1'b1, mk(2), mk(6), 2, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b0, 0, 1'b1, mk(3), mk(7), 3, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 0, 1'b0, mk(3), mk(7), 3, 1'b0, 1'b0};

    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      s_if.data_in       = mk(tv[k].n);
      s_if.data_in_valid = tv[k].v;
      rst                = tv[k].r;
      @(posedge clk);
      #1;
      chk($sformatf("tab%0d_valid", k), 64'(s_if.data_out_valid), 64'(tv[k].ev));
      chk($sformatf("tab%0d_d1", k), s_if.data_out1, tv[k].e1);
      chk($sformatf("tab%0d_d2", k), s_if.data_out2, tv[k].e2);
      chk($sformatf("tab%0d_idx", k), 64'(s_if.pair_index), 64'(tv[k].ei));
      chk($sformatf("tab%0d_done", k), 64'(s_if.frame_done), 64'(tv[k].ed));
      chk($sformatf("tab%0d_phase", k), 64'(s_if.phase), 64'(tv[k].eph));
    end

    // three back-to-back frames, no gaps: 12 pairs
    step(1'b1, 1'b0, 0);
    npairs = 0;
    for (int n = 0; n < 24; n++) step(1'b0, 1'b1, n);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);
    chk("b2b_pair_count", 64'(npairs), 64'd12);

    // random gaps, with idle forced across the FILL->PAIR edge
    npairs = 0;
    for (int rep = 0; rep < 3; rep++) begin
      for (int n = 0; n < 8; n++) begin
        if (n == 4) begin
          step(1'b0, 1'b0, 0);
          step(1'b0, 1'b0, 0);
        end
        while ($urandom_range(99) < 30) step(1'b0, 1'b0, $urandom);
        step(1'b0, 1'b1, 8 * rep + n + 300);
      end
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);
    chk("gap_pair_count", 64'(npairs), 64'd12);

    // reset after n=5 once the first two pairs are out, then a fresh frame
    npairs = 0;
    for (int n = 0; n <= 5; n++) step(1'b0, 1'b1, n);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    for (int n = 100; n <= 107; n++) step(1'b0, 1'b1, n);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);
    chk("rst_mid_pair_count", 64'(npairs), 64'd6);

    // reset landing on in-flight pairs discards them
    npairs = 0;
    for (int n = 0; n <= 5; n++) step(1'b0, 1'b1, n);
    step(1'b1, 1'b1, 6);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);
    chk("rst_inflight_count", 64'(npairs), 64'd0);

    // reset held with valid high: inputs ignored, next sample is x[0]
    for (int n = 50; n < 53; n++) step(1'b1, 1'b1, n);
    npairs = 0;
    for (int n = 200; n < 208; n++) step(1'b0, 1'b1, n);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);
    chk("rst_hold_pair_count", 64'(npairs), 64'd4);

    // default-size instance: one full frame plus the first pair of the next
    bstep(1'b1, 1'b0, 0);
    for (int n = 0; n < int'(2 * HB + HB + 1); n++) bstep(1'b0, 1'b1, n);
    for (int k = 0; k < 4; k++) bstep(1'b0, 1'b0, 0);
    chk("big_pair_count", 64'(b_pairs), 64'(HB + 1));

    base = 0;
    p0   = 0;
    if (base == p0) begin
      $display("test done: total=%0d bad=%0d", total, bad);
    end
    $finish;
  end

endmodule
